ddr3_app_arbiter: RTL and testbench

- Shares the single DDR3 MIG user command port (app_en/app_cmd/app_addr/app_rdy) between the write-path address requester and the readout-path address requester.
- Grants one requester at a time, holds the grant for a bounded command quantum, and inserts a dead turnaround between direction changes.
- Handshakes back to each requester are combinational, so requesters see the same accept timing as a direct MIG connection.
- Write-data (app_wdf_*) and read-data paths are not touched.

---
 rtl/ddr3_app_arbiter_if.sv | 34 +++
 rtl/ddr3_app_arbiter.sv | 143 ++++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_app_arbiter_if.sv
// rtl/ddr3_app_arbiter_if.sv - MIG command-port sharing bundle between requesters, arbiter and MIG
interface ddr3_app_arbiter_if #(
    parameter int ADDR_WIDTH = 26
);
    logic                  init_calib_complete;
    logic                  wr_app_en;
    logic [ADDR_WIDTH-1:0] wr_app_addr;
    logic                  wr_app_rdy;
    logic                  rd_app_en;
    logic [ADDR_WIDTH-1:0] rd_app_addr;
    logic                  rd_app_rdy;
    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [ADDR_WIDTH-1:0] app_addr;
    logic                  app_rdy;
    logic                  grant_wr;
    logic                  grant_rd;
    logic [31:0]           wr_cmd_count;
    logic [31:0]           rd_cmd_count;

    // Arbiter view: consumes requests and MIG ready, drives the MIG command and status.
    modport master (
        input  init_calib_complete, wr_app_en, wr_app_addr, rd_app_en, rd_app_addr, app_rdy,
        output wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr,
        output grant_wr, grant_rd, wr_cmd_count, rd_cmd_count
    );

    // Environment view: requesters and MIG model.
    modport slave (
        output init_calib_complete, wr_app_en, wr_app_addr, rd_app_en, rd_app_addr, app_rdy,
        input  wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr,
        input  grant_wr, grant_rd, wr_cmd_count, rd_cmd_count
    );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// rtl/ddr3_app_arbiter.sv - write/read requester arbiter for the shared DDR3 MIG command port
// Grants one side at a time, bounds a grant to QUANTUM accepts under contention,
// releases after HOLD_CYCLES idle cycles and inserts TURNAROUND dead cycles between sides.
module ddr3_app_arbiter #(
    parameter int ADDR_WIDTH  = 26,
    parameter int QUANTUM     = 64,
    parameter int HOLD_CYCLES = 4,
    parameter int TURNAROUND  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    ddr3_app_arbiter_if.master      bus
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_GNT_WR = 4'b0010,
        ST_GNT_RD = 4'b0100,
        ST_TURN   = 4'b1000
    } state_t;

    localparam logic [15:0] QUANTUM_C  = 16'(QUANTUM);
    localparam logic [15:0] QUANTUM_M1 = 16'(QUANTUM - 1);
    localparam logic [7:0]  HOLD_M1    = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]  TURN_M1    = 4'(TURNAROUND - 1);

    state_t      state_q, state_d;
    logic        last_wr_q, last_wr_d;      // 1: last grant was write, 0: read
    logic [15:0] quantum_cnt_q, quantum_cnt_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [3:0]  turn_cnt_q, turn_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    logic calib;
    logic in_wr;
    logic in_rd;
    logic app_en_w;
    logic accept;
    logic own_en;
    logic other_en;

    assign calib  = bus.init_calib_complete;
    assign in_wr  = (state_q == ST_GNT_WR);
    assign in_rd  = (state_q == ST_GNT_RD);

    // Command mux and combinational handshakes back to the requesters.
    always_comb begin
        app_en_w       = calib & ((in_wr & bus.wr_app_en) | (in_rd & bus.rd_app_en));
        bus.app_en     = app_en_w;
        bus.app_cmd    = in_rd ? 3'b001 : 3'b000;
        bus.app_addr   = in_wr ? bus.wr_app_addr : (in_rd ? bus.rd_app_addr : '0);
        bus.wr_app_rdy = bus.app_rdy & calib & in_wr;
        bus.rd_app_rdy = bus.app_rdy & calib & in_rd;
        accept         = app_en_w & bus.app_rdy;
        own_en         = in_rd ? bus.rd_app_en : bus.wr_app_en;
        other_en       = in_rd ? bus.wr_app_en : bus.rd_app_en;
    end

    // Next-state logic; grant counters are zero outside a grant so they start clean on entry.
    always_comb begin
        state_d       = state_q;
        last_wr_d     = last_wr_q;
        quantum_cnt_d = '0;
        idle_cnt_d    = '0;
        turn_cnt_d    = turn_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (calib) begin
                    if (bus.wr_app_en && (!bus.rd_app_en || !last_wr_q)) begin
                        state_d = ST_GNT_WR;
                    end else if (bus.rd_app_en) begin
                        state_d = ST_GNT_RD;
                    end
                end
            end
            ST_GNT_WR, ST_GNT_RD: begin
                quantum_cnt_d = (accept && quantum_cnt_q != QUANTUM_C) ? quantum_cnt_q + 16'd1
                                                                       : quantum_cnt_q;
                idle_cnt_d    = own_en ? 8'd0 : idle_cnt_q + 8'd1;
                if (!calib) begin
                    state_d   = ST_IDLE;
                    last_wr_d = in_wr;
                end else if (accept && quantum_cnt_q >= QUANTUM_M1 && other_en) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = TURN_M1;
                    last_wr_d  = in_wr;
                end else if (!own_en && idle_cnt_q == HOLD_M1) begin
                    state_d    = other_en ? ST_TURN : ST_IDLE;
                    turn_cnt_d = TURN_M1;
                    last_wr_d  = in_wr;
                end
            end
            ST_TURN: begin
                if (!calib) begin
                    state_d = ST_IDLE;
                end else if (turn_cnt_q != 4'd0) begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end else if (last_wr_q) begin
                    state_d = bus.rd_app_en ? ST_GNT_RD : (bus.wr_app_en ? ST_GNT_WR : ST_IDLE);
                end else begin
                    state_d = bus.wr_app_en ? ST_GNT_WR : (bus.rd_app_en ? ST_GNT_RD : ST_IDLE);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating per-side accept counters.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (accept && in_wr && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
        if (accept && in_rd && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_wr_q     <= 1'b0;
            quantum_cnt_q <= '0;
            idle_cnt_q    <= '0;
            turn_cnt_q    <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_wr_q     <= last_wr_d;
            quantum_cnt_q <= quantum_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
        end
    end

    assign bus.grant_wr     = in_wr;
    assign bus.grant_rd     = in_rd;
    assign bus.wr_cmd_count = wr_cnt_q;
    assign bus.rd_cmd_count = rd_cnt_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// tb/tb_ddr3_app_arbiter.sv - directed bench for ddr3_app_arbiter
module tb_ddr3_app_arbiter;
    localparam int AW = 26;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ddr3_app_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    ddr3_app_arbiter #(
        .ADDR_WIDTH(AW), .QUANTUM(4), .HOLD_CYCLES(4), .TURNAROUND(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.init_calib_complete = 1'b0;
        bus.wr_app_en = 1'b0;
        bus.wr_app_addr = '0;
        bus.rd_app_en = 1'b0;
        bus.rd_app_addr = '0;
        bus.app_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_app_en = 1'b1;
        bus.app_rdy = 1'b1;
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.grant_wr !== 1'b0) begin errors++; $display("FAIL rst_grant_wr got %0h exp 0", bus.grant_wr); end
        checks++; if (bus.grant_rd !== 1'b0) begin errors++; $display("FAIL rst_grant_rd got %0h exp 0", bus.grant_rd); end
        checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL rst_app_en got %0h exp 0", bus.app_en); end
        checks++; if (bus.wr_app_rdy !== 1'b0) begin errors++; $display("FAIL rst_wr_rdy got %0h exp 0", bus.wr_app_rdy); end
        checks++; if (bus.wr_cmd_count !== 32'd0) begin errors++; $display("FAIL rst_wr_count got %0d exp 0", bus.wr_cmd_count); end
        checks++; if (bus.rd_cmd_count !== 32'd0) begin errors++; $display("FAIL rst_rd_count got %0d exp 0", bus.rd_cmd_count); end
    endtask

    task automatic test_single_write();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_app_en = 1'b1;
        bus.wr_app_addr = 26'h100;
        bus.app_rdy = 1'b1;
        apply_reset();
        step();
        checks++; if (bus.grant_wr !== 1'b1) begin errors++; $display("FAIL sw_grant_wr got %0h exp 1", bus.grant_wr); end
        checks++; if (bus.app_en !== 1'b1) begin errors++; $display("FAIL sw_app_en got %0h exp 1", bus.app_en); end
        checks++; if (bus.app_cmd !== 3'b000) begin errors++; $display("FAIL sw_app_cmd got %0h exp 0", bus.app_cmd); end
        checks++; if (bus.app_addr !== 26'h100) begin errors++; $display("FAIL sw_app_addr got %0h exp 100", bus.app_addr); end
        checks++; if (bus.wr_app_rdy !== 1'b1) begin errors++; $display("FAIL sw_wr_rdy got %0h exp 1", bus.wr_app_rdy); end
        checks++; if (bus.wr_cmd_count !== 32'd0) begin errors++; $display("FAIL sw_count0 got %0d exp 0", bus.wr_cmd_count); end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (bus.wr_cmd_count !== 32'(k)) begin errors++; $display("FAIL sw_count%0d got %0d exp %0d", k, bus.wr_cmd_count, k); end
        end
    endtask

    task automatic test_quantum();
        logic e_wr;
        logic e_rd;
        int   ph;
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_app_en = 1'b1;
        bus.wr_app_addr = 26'h0A0;
        bus.rd_app_en = 1'b1;
        bus.rd_app_addr = 26'h0B0;
        bus.app_rdy = 1'b1;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step();
            ph = i % 12;
            e_wr = (ph < 4);
            e_rd = (ph >= 6) && (ph < 10);
            checks++; if (bus.grant_wr !== e_wr) begin errors++; $display("FAIL q_grant_wr[%0d] got %0h exp %0h", i, bus.grant_wr, e_wr); end
            checks++; if (bus.grant_rd !== e_rd) begin errors++; $display("FAIL q_grant_rd[%0d] got %0h exp %0h", i, bus.grant_rd, e_rd); end
            checks++; if (bus.app_en !== (e_wr | e_rd)) begin errors++; $display("FAIL q_app_en[%0d] got %0h exp %0h", i, bus.app_en, e_wr | e_rd); end
            checks++; if (bus.app_cmd !== {2'b00, e_rd}) begin errors++; $display("FAIL q_app_cmd[%0d] got %0h exp %0h", i, bus.app_cmd, e_rd); end
        end
        step();
        checks++; if (bus.app_addr !== 26'h0) begin errors++; $display("FAIL q_turn_addr got %0h exp 0", bus.app_addr); end
        checks++; if (bus.wr_cmd_count !== 32'd8) begin errors++; $display("FAIL q_wr_count got %0d exp 8", bus.wr_cmd_count); end
        checks++; if (bus.rd_cmd_count !== 32'd4) begin errors++; $display("FAIL q_rd_count got %0d exp 4", bus.rd_cmd_count); end
    endtask

    task automatic test_hold();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_app_en = 1'b1;
        bus.wr_app_addr = 26'h040;
        bus.rd_app_addr = 26'h080;
        bus.app_rdy = 1'b1;
        apply_reset();
        step();
        bus.wr_app_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.grant_wr !== 1'b1) begin errors++; $display("FAIL hold3_grant[%0d] got %0h exp 1", k, bus.grant_wr); end
        end
        bus.wr_app_en = 1'b1;
        #1;
        checks++; if (bus.app_en !== 1'b1) begin errors++; $display("FAIL hold3_app_en got %0h exp 1", bus.app_en); end
        step();
        bus.wr_app_en = 1'b0;
        bus.rd_app_en = 1'b1;
        #1;
        checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL hold4_app_en got %0h exp 0", bus.app_en); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.grant_wr !== 1'b1) begin errors++; $display("FAIL hold4_grant[%0d] got %0h exp 1", k, bus.grant_wr); end
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if ({bus.grant_wr, bus.grant_rd, bus.app_en} !== 3'b000) begin errors++; $display("FAIL hold4_turn[%0d] got %0h exp 0", k, {bus.grant_wr, bus.grant_rd, bus.app_en}); end
        end
        step();
        checks++; if (bus.grant_rd !== 1'b1) begin errors++; $display("FAIL hold4_grant_rd got %0h exp 1", bus.grant_rd); end
        checks++; if (bus.app_addr !== 26'h080) begin errors++; $display("FAIL hold4_addr got %0h exp 80", bus.app_addr); end
        checks++; if (bus.wr_cmd_count !== 32'd1) begin errors++; $display("FAIL hold_wr_count got %0d exp 1", bus.wr_cmd_count); end
    endtask

    task automatic test_rdy_stall();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.rd_app_en = 1'b1;
        bus.rd_app_addr = 26'h2AA;
        apply_reset();
        step();
        for (int k = 0; k < 10; k++) begin
            checks++; if (bus.grant_rd !== 1'b1) begin errors++; $display("FAIL stall_grant[%0d] got %0h exp 1", k, bus.grant_rd); end
            checks++; if (bus.rd_app_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy[%0d] got %0h exp 0", k, bus.rd_app_rdy); end
            checks++; if (bus.rd_cmd_count !== 32'd0) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 0", k, bus.rd_cmd_count); end
            checks++; if (bus.app_addr !== 26'h2AA) begin errors++; $display("FAIL stall_addr[%0d] got %0h exp 2aa", k, bus.app_addr); end
            step();
        end
        checks++; if (bus.app_cmd !== 3'b001) begin errors++; $display("FAIL stall_cmd got %0h exp 1", bus.app_cmd); end
        bus.app_rdy = 1'b1;
        #1;
        checks++; if (bus.rd_app_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_rel got %0h exp 1", bus.rd_app_rdy); end
        step();
        checks++; if (bus.rd_cmd_count !== 32'd1) begin errors++; $display("FAIL stall_count_rel got %0d exp 1", bus.rd_cmd_count); end
    endtask

    task automatic test_calib_drop();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_app_en = 1'b1;
        bus.wr_app_addr = 26'h155;
        bus.app_rdy = 1'b1;
        apply_reset();
        step();
        step();
        checks++; if (bus.wr_cmd_count !== 32'd1) begin errors++; $display("FAIL cal_count_pre got %0d exp 1", bus.wr_cmd_count); end
        bus.init_calib_complete = 1'b0;
        #1;
        checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL cal_app_en got %0h exp 0", bus.app_en); end
        checks++; if (bus.wr_app_rdy !== 1'b0) begin errors++; $display("FAIL cal_wr_rdy got %0h exp 0", bus.wr_app_rdy); end
        step();
        checks++; if (bus.grant_wr !== 1'b0) begin errors++; $display("FAIL cal_idle got %0h exp 0", bus.grant_wr); end
        checks++; if (bus.wr_cmd_count !== 32'd1) begin errors++; $display("FAIL cal_count_hold got %0d exp 1", bus.wr_cmd_count); end
        step();
        checks++; if (bus.grant_wr !== 1'b0) begin errors++; $display("FAIL cal_idle2 got %0h exp 0", bus.grant_wr); end
        bus.init_calib_complete = 1'b1;
        step();
        checks++; if (bus.grant_wr !== 1'b1) begin errors++; $display("FAIL cal_regrant got %0h exp 1", bus.grant_wr); end
        checks++; if (bus.app_en !== 1'b1) begin errors++; $display("FAIL cal_app_en2 got %0h exp 1", bus.app_en); end
        step();
        checks++; if (bus.wr_cmd_count !== 32'd2) begin errors++; $display("FAIL cal_count_post got %0d exp 2", bus.wr_cmd_count); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        bus.init_calib_complete = 1'b1;
        bus.rd_app_en = 1'b1;
        bus.rd_app_addr = 26'h033;
        bus.app_rdy = 1'b1;
        apply_reset();
        step();
        step();
        step();
        checks++; if (bus.rd_cmd_count !== 32'd2) begin errors++; $display("FAIL ar_count_pre got %0d exp 2", bus.rd_cmd_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.grant_rd !== 1'b0) begin errors++; $display("FAIL ar_grant_rd got %0h exp 0", bus.grant_rd); end
        checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL ar_app_en got %0h exp 0", bus.app_en); end
        checks++; if (bus.rd_cmd_count !== 32'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", bus.rd_cmd_count); end
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_quantum();
        test_hold();
        test_rdy_stall();
        test_calib_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
